alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the ALU.
- Accepts a decoded-instruction beat (opcode, funct, rs/rt register data, 16-bit immediate) over a valid/ready handshake.
- Translates it into the ALU's 4-bit op select and the two N-bit operands, and presents them registered to the ALU/execute stage over a second valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready_o.

Parameters:
- N, 32, operand and datapath width; must be >= 16.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- in_valid_i  input  1  upstream beat valid.
- in_ready_o  output  1  stage can accept a beat.
- opcode_i  input  6  MIPS primary opcode.
- funct_i  input  6  MIPS funct field; used only when opcode_i==0.
- rs_data_i  input  N  first source register value.
- rt_data_i  input  N  second source register value.
- imm_i  input  16  I-type immediate.
- out_valid_o  output  1  issued beat valid.
- out_ready_i  input  1  downstream accepts beat.
- op_sel_o  output  4  ALU op select.
- op_a_o  output  N  ALU operand A.
- op_b_o  output  N  ALU operand B.
- illegal_o  output  1  issued beat carried an unsupported encoding.

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid_i && in_ready_o.
  - Output transfer occurs when out_valid_o && out_ready_i.
  - Once out_valid_o is high, op_sel_o, op_a_o, op_b_o and illegal_o hold stable until the output transfer.
- Op select codes: SUM=0000, SUB=0010, AND=0100, OR=0101, XOR=0110, NOR=0111, SLT=1010.
- Decode for opcode 0x00 (R-type), with op_a=rs, op_b=rt:
  - funct 0x20/0x21 -> SUM
  - funct 0x22/0x23 -> SUB
  - funct 0x24 -> AND
  - funct 0x25 -> OR
  - funct 0x26 -> XOR
  - funct 0x27 -> NOR
  - funct 0x2A -> SLT
- Decode for I-type, with op_a=rs:
  - 0x08/0x09 -> SUM, op_b = sign-extended imm.
  - 0x0A -> SLT, op_b = sign-extended imm.
  - 0x0C -> AND, op_b = zero-extended imm.
  - 0x0D -> OR, op_b = zero-extended imm.
  - 0x0E -> XOR, op_b = zero-extended imm.
  - Extension: sign-extend replicates imm[15] into bits N-1:16; zero-extend fills those bits with 0.
- Any other opcode, or R-type with another funct:
  - illegal_o=1, op_sel_o=SUM, op_a_o=0, op_b_o=0.
  - The beat is still issued, never dropped.
- Decode is combinational on the inputs; results are captured into the buffer at the input transfer.
- Buffer states:
  - EMPTY: no valid entry. out_valid_o=0, in_ready_o=1.
  - ONE: main entry valid. out_valid_o=1, in_ready_o=1.
  - FULL: main + skid valid. out_valid_o=1, in_ready_o=0.
- Transitions:
  - EMPTY + in transfer -> ONE (main loaded).
  - ONE + in transfer + out transfer -> ONE (main reloaded with the new beat).
  - ONE + in transfer, no out -> FULL (new beat into skid).
  - ONE + out only -> EMPTY.
  - FULL + out transfer -> ONE (skid moves to main).
  - FULL never accepts, since in_ready_o=0.
- Latency and throughput:
  - Latency is 1 cycle: a beat accepted at edge k is visible on the outputs after edge k.
  - Sustained throughput is 1 beat/cycle while out_ready_i=1.
  - Order is strictly FIFO.
- in_ready_o is driven from a register (= !skid_valid). It is never combinationally dependent on out_ready_i.
- Reset, asynchronous assert while rst_ni=0:
  - State -> EMPTY.
  - out_valid_o=0, illegal_o=0, op_sel_o=0000, op_a_o=0, op_b_o=0, in_ready_o=1.
  - An in-flight beat is discarded.
  - Deassertion is synchronous to clk_i by the surrounding reset synchroniser.
- Downstream stall:
  - out_ready_i=0 with in_valid_i=1 fills to FULL after 2 accepted beats.
  - in_ready_o drops the cycle after the second accept.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- When defined:
  - Adds outputs issued_cnt_o[31:0] and illegal_cnt_o[31:0].
  - issued_cnt_o increments on each output transfer; illegal_cnt_o increments on each output transfer with illegal_o=1.
  - Both counters wrap from 0xFFFFFFFF to 0 and reset to 0.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- R-type ADD: opcode 0x00, funct 0x20, rs=5, rt=7, out_ready_i=1 -> next cycle out_valid_o=1, op_sel_o=0000, op_a_o=5, op_b_o=7, illegal_o=0.
- Immediate extension: SLTI 0x0A with imm=0xFFFF, rs=3 -> op_sel_o=1010, op_b_o=0xFFFFFFFF. ORI 0x0D with imm=0x8001 -> op_sel_o=0101, op_b_o=0x00008001.
- Illegal: opcode 0x23, or R-type funct 0x08 -> issued with illegal_o=1, op_sel_o=0000, op_a_o=op_b_o=0.
- Backpressure: out_ready_i=0, three consecutive valid beats A, B, C -> A, B accepted, in_ready_o=0 from the cycle after B, C held. Raise out_ready_i -> outputs A, B, C in order, no loss or duplication.
- Streaming: 16 back-to-back beats with out_ready_i=1 -> 16 output transfers on 16 consecutive cycles, in_ready_o constantly 1.
- Reset mid-operation: FULL state, rst_ni pulled low asynchronously between edges -> out_valid_o=0, in_ready_o=1 immediately. With ALU_ISSUE_STATS_EN: counters read 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: the pipeline stage that feeds the ALU.
//
// It decodes a MIPS instruction beat (opcode/funct, rs/rt data, 16-bit
// immediate) into a 4-bit ALU op select and two N-bit operands. The result
// is held in a 2-entry skid buffer, so the stage runs at full throughput
// while in_ready_o comes straight from a flop.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   in_valid_i / in_ready_o  upstream handshake
//   opcode_i, funct_i        MIPS primary opcode / funct (funct used when opcode==0)
//   rs_data_i, rt_data_i     source register values (N bits)
//   imm_i                    16-bit I-type immediate
//   out_valid_o/out_ready_i  downstream handshake
//   op_sel_o, op_a_o, op_b_o ALU op select and operands
//   illegal_o                issued beat carried an unsupported encoding
//
// Optional: define ALU_ISSUE_STATS_EN to add issued_cnt_o / illegal_cnt_o,
// two 32-bit wrapping transfer counters.
module alu_issue_stage #(
  parameter int unsigned N = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   funct_i,
  input  logic [N-1:0] rs_data_i,
  input  logic [N-1:0] rt_data_i,
  input  logic [15:0]  imm_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [3:0]   op_sel_o,
  output logic [N-1:0] op_a_o,
  output logic [N-1:0] op_b_o,
  output logic         illegal_o
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]  issued_cnt_o,
  output logic [31:0]  illegal_cnt_o
`endif
);

  localparam logic [3:0] OP_SUM = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1010;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

  state_e state_q, state_d;
  logic   in_ready_q;
  logic   in_fire, out_fire;
  logic   load_main_in, load_main_skid, load_skid;

  // Decoded beat
  logic [3:0]   dec_sel;
  logic [N-1:0] dec_a, dec_b;
  logic         dec_ill;
  logic [N-1:0] imm_sext, imm_zext;

  // Buffer entries
  logic [3:0]   main_sel_q, skid_sel_q;
  logic [N-1:0] main_a_q, main_b_q, skid_a_q, skid_b_q;
  logic         main_ill_q, skid_ill_q;

  // Size casts keep this correct for N == 16, where a zero-count
  // replication would be illegal.
  assign imm_sext = N'($signed(imm_i));
  assign imm_zext = N'(imm_i);

  always_comb begin
    dec_sel = OP_SUM;
    dec_a   = rs_data_i;
    dec_b   = rt_data_i;
    dec_ill = 1'b0;
    unique case (opcode_i)
      6'h00: begin
        unique case (funct_i)
          6'h20, 6'h21: dec_sel = OP_SUM;
          6'h22, 6'h23: dec_sel = OP_SUB;
          6'h24:        dec_sel = OP_AND;
          6'h25:        dec_sel = OP_OR;
          6'h26:        dec_sel = OP_XOR;
          6'h27:        dec_sel = OP_NOR;
          6'h2A:        dec_sel = OP_SLT;
          default:      dec_ill = 1'b1;
        endcase
      end
      6'h08, 6'h09: begin dec_sel = OP_SUM; dec_b = imm_sext; end
      6'h0A:        begin dec_sel = OP_SLT; dec_b = imm_sext; end
      6'h0C:        begin dec_sel = OP_AND; dec_b = imm_zext; end
      6'h0D:        begin dec_sel = OP_OR;  dec_b = imm_zext; end
      6'h0E:        begin dec_sel = OP_XOR; dec_b = imm_zext; end
      default:      dec_ill = 1'b1;
    endcase
    // Illegal beats still issue, but with neutral operands.
    if (dec_ill) begin
      dec_sel = OP_SUM;
      dec_a   = '0;
      dec_b   = '0;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != S_EMPTY);
  assign in_fire     = in_valid_i && in_ready_q;
  assign out_fire    = out_valid_o && out_ready_i;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          state_d      = S_ONE;
          load_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          state_d   = S_FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (out_fire) begin
          state_d        = S_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // in_ready is registered from the next state so it never depends
  // combinationally on out_ready_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_FULL);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_sel_q <= '0;
      main_a_q   <= '0;
      main_b_q   <= '0;
      main_ill_q <= 1'b0;
      skid_sel_q <= '0;
      skid_a_q   <= '0;
      skid_b_q   <= '0;
      skid_ill_q <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_sel_q <= dec_sel;
        main_a_q   <= dec_a;
        main_b_q   <= dec_b;
        main_ill_q <= dec_ill;
      end else if (load_main_skid) begin
        main_sel_q <= skid_sel_q;
        main_a_q   <= skid_a_q;
        main_b_q   <= skid_b_q;
        main_ill_q <= skid_ill_q;
      end
      if (load_skid) begin
        skid_sel_q <= dec_sel;
        skid_a_q   <= dec_a;
        skid_b_q   <= dec_b;
        skid_ill_q <= dec_ill;
      end
    end
  end

  assign op_sel_o  = main_sel_q;
  assign op_a_o    = main_a_q;
  assign op_b_o    = main_b_q;
  assign illegal_o = main_ill_q;

`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issued_cnt_o  <= '0;
      illegal_cnt_o <= '0;
    end else if (out_fire) begin
      issued_cnt_o <= issued_cnt_o + 32'd1;
      if (main_ill_q) illegal_cnt_o <= illegal_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage (N = 32): decode table plus
// backpressure, streaming and asynchronous-reset sequences.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [5:0]  opcode, funct;
  logic [31:0] rs_data, rt_data;
  logic [15:0] imm;
  logic        out_valid, out_ready;
  logic [3:0]  op_sel;
  logic [31:0] op_a, op_b;
  logic        illegal;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issued_cnt, illegal_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.N(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .opcode_i    (opcode),
    .funct_i     (funct),
    .rs_data_i   (rs_data),
    .rt_data_i   (rt_data),
    .imm_i       (imm),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .op_sel_o    (op_sel),
    .op_a_o      (op_a),
    .op_b_o      (op_b),
    .illegal_o   (illegal)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .issued_cnt_o  (issued_cnt),
    .illegal_cnt_o (illegal_cnt)
`endif
  );

  typedef struct {
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } vec_t;

  localparam int unsigned NV = 18;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [5:0] opc, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im);
    opcode   = opc;
    funct    = fn;
    rs_data  = rs;
    rt_data  = rt;
    imm      = im;
    in_valid = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{6'h00, 6'h20, 32'd5,  32'd7,  16'h0000, 4'b0000, 32'd5,  32'd7,        1'b0};
    vecs[1]  = '{6'h00, 6'h21, 32'd10, 32'd3,  16'h1234, 4'b0000, 32'd10, 32'd3,        1'b0};
    vecs[2]  = '{6'h00, 6'h22, 32'd9,  32'd4,  16'h0000, 4'b0010, 32'd9,  32'd4,        1'b0};
    vecs[3]  = '{6'h00, 6'h23, 32'hA,  32'hB,  16'h0000, 4'b0010, 32'hA,  32'hB,        1'b0};
    vecs[4]  = '{6'h00, 6'h24, 32'hF0, 32'h3C, 16'h0000, 4'b0100, 32'hF0, 32'h3C,       1'b0};
    vecs[5]  = '{6'h00, 6'h25, 32'h1,  32'h2,  16'h0000, 4'b0101, 32'h1,  32'h2,        1'b0};
    vecs[6]  = '{6'h00, 6'h26, 32'h3,  32'h4,  16'h0000, 4'b0110, 32'h3,  32'h4,        1'b0};
    vecs[7]  = '{6'h00, 6'h27, 32'h5,  32'h6,  16'h0000, 4'b0111, 32'h5,  32'h6,        1'b0};
    vecs[8]  = '{6'h00, 6'h2A, 32'hFFFFFFFF, 32'h1, 16'h0, 4'b1010, 32'hFFFFFFFF, 32'h1, 1'b0};
    vecs[9]  = '{6'h08, 6'h00, 32'd1,  32'd99, 16'h8000, 4'b0000, 32'd1,  32'hFFFF8000, 1'b0};
    vecs[10] = '{6'h09, 6'h00, 32'd2,  32'd99, 16'h7FFF, 4'b0000, 32'd2,  32'h00007FFF, 1'b0};
    vecs[11] = '{6'h0A, 6'h00, 32'd3,  32'd99, 16'hFFFF, 4'b1010, 32'd3,  32'hFFFFFFFF, 1'b0};
    vecs[12] = '{6'h0C, 6'h00, 32'h77, 32'd99, 16'hF0F0, 4'b0100, 32'h77, 32'h0000F0F0, 1'b0};
    vecs[13] = '{6'h0D, 6'h00, 32'h88, 32'd99, 16'h8001, 4'b0101, 32'h88, 32'h00008001, 1'b0};
    vecs[14] = '{6'h0E, 6'h00, 32'h99, 32'd99, 16'hFFFF, 4'b0110, 32'h99, 32'h0000FFFF, 1'b0};
    vecs[15] = '{6'h23, 6'h20, 32'h12, 32'h34, 16'h5678, 4'b0000, 32'h0,  32'h0,        1'b1};
    vecs[16] = '{6'h00, 6'h08, 32'h12, 32'h34, 16'h5678, 4'b0000, 32'h0,  32'h0,        1'b1};
    vecs[17] = '{6'h0D, 6'h27, 32'h40, 32'h50, 16'h0001, 4'b0101, 32'h40, 32'h00000001, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; funct = '0; rs_data = '0; rt_data = '0; imm = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_op_sel",    {28'd0, op_sel},    32'd0);
    check("rst_op_a",      op_a, 32'd0);
    check("rst_op_b",      op_b, 32'd0);
    check("rst_illegal",   {31'd0, illegal},   32'd0);
    rst_n = 1'b1;

    // Decode table, one beat at a time with the sink always ready.
    out_ready = 1'b1;
    for (int unsigned i = 0; i < NV; i++) begin
      @(negedge clk);
      check("vec_in_ready", {31'd0, in_ready}, 32'd1);
      drive(vecs[i].opc, vecs[i].fn, vecs[i].rs, vecs[i].rt, vecs[i].imm);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_sel", i),   {28'd0, op_sel},    {28'd0, vecs[i].sel});
      check($sformatf("vec%0d_a", i),     op_a, vecs[i].a);
      check($sformatf("vec%0d_b", i),     op_b, vecs[i].b);
      check($sformatf("vec%0d_ill", i),   {31'd0, illegal},   {31'd0, vecs[i].ill});
    end
    @(posedge clk); #1;
    check("drain_empty", {31'd0, out_valid}, 32'd0);

    // Backpressure: A, B fill the buffer; C must wait until a slot frees.
    @(negedge clk);
    out_ready = 1'b0;
    drive(6'h00, 6'h20, 32'h11, 32'h0, 16'h0);
    @(negedge clk);
    check("bp_ready_after_a", {31'd0, in_ready}, 32'd1);
    drive(6'h00, 6'h20, 32'h22, 32'h0, 16'h0);
    @(negedge clk);
    check("bp_ready_after_b", {31'd0, in_ready}, 32'd0);
    check("bp_head_a", op_a, 32'h11);
    drive(6'h00, 6'h20, 32'h33, 32'h0, 16'h0);
    @(negedge clk);
    check("bp_still_full", {31'd0, in_ready}, 32'd0);
    check("bp_hold_a",     op_a, 32'h11);
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_out_b", op_a, 32'h22);
    check("bp_ready_again", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_out_c", op_a, 32'h33);
    check("bp_c_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Streaming: 16 back-to-back beats, one output per cycle.
    for (int unsigned i = 0; i <= 16; i++) begin
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      if (i > 0) begin
        check("stream_valid", {31'd0, out_valid}, 32'd1);
        check($sformatf("stream_a%0d", i - 1), op_a, 32'd99 + i);
      end
      if (i < 16) drive(6'h00, 6'h22, 32'd100 + i, 32'd1, 16'h0);
      else in_valid = 1'b0;
      @(negedge clk);
    end
    check("stream_empty", {31'd0, out_valid}, 32'd0);

`ifdef ALU_ISSUE_STATS_EN
    // 18 table beats (2 illegal) + 3 backpressure + 16 streaming.
    check("cnt_issued",  issued_cnt,  32'd37);
    check("cnt_illegal", illegal_cnt, 32'd2);
`endif

    // Asynchronous reset from FULL, asserted between clock edges.
    out_ready = 1'b0;
    drive(6'h23, 6'h00, 32'h1, 32'h2, 16'h3);
    @(negedge clk);
    drive(6'h00, 6'h20, 32'h44, 32'h55, 16'h0);
    @(negedge clk);
    in_valid = 1'b0;
    check("full_before_rst", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready",  {31'd0, in_ready},  32'd1);
    check("arst_op_a",      op_a, 32'd0);
    check("arst_illegal",   {31'd0, illegal},   32'd0);
`ifdef ALU_ISSUE_STATS_EN
    check("arst_issued_cnt",  issued_cnt,  32'd0);
    check("arst_illegal_cnt", illegal_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_empty", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
